// File: rtl/clk_rst_pkg.sv
// Shared clock/reset definitions: reset-sequencer state encoding, default timing
// and counter width.
package clk_rst_pkg;

  localparam int CNT_W           = 16;
  localparam int STABLE_CYC_DEF  = 64;
  localparam int STEP_CYC_DEF    = 16;
  localparam int HOLD_CYC_DEF    = 32;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    REL_SYS   = 3'd2,
    REL_FB    = 3'd3,
    REL_PIX   = 3'd4,
    RUN       = 3'd5,
    HOLD      = 3'd6
  } seq_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-stage synchronizer with async active-low reset to 0.
// Used for any level signal crossing into the local clock domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_bit: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  // Shift chain; the first stage may go metastable, later stages filter it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Power-up / recovery reset sequencer: waits for a stable PLL lock, then releases
// sys -> fb -> pix resets and video_en in order; lock loss or sw request restarts it.
module rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int STABLE_CYC  = STABLE_CYC_DEF,
  parameter int STEP_CYC    = STEP_CYC_DEF,
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sw_rst_req,
  output logic       rst_sys_n,
  output logic       rst_fb_n,
  output logic       rst_pix_n,
  output logic       video_en,
  output logic       busy,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt
);

  if (STABLE_CYC < 1 || STABLE_CYC > 65536) begin : g_bad_stable
    $error("rst_sequencer: STABLE_CYC out of range 1..65536");
  end
  if (STEP_CYC < 1 || STEP_CYC > 65536) begin : g_bad_step
    $error("rst_sequencer: STEP_CYC out of range 1..65536");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 65536) begin : g_bad_hold
    $error("rst_sequencer: HOLD_CYC out of range 1..65536");
  end

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  logic             lock_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_q, loss_d;
  logic             sys_q, fb_q, pix_q, video_q, busy_q;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i  (clk_in),
    .rst_ni (rst),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  // Next-state logic; the counter restarts from zero on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = SETTLE;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = REL_SYS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      REL_SYS, REL_FB, REL_PIX, RUN: begin
        if (!lock_s || sw_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
          if (!lock_s) begin
            loss_d = sat_inc8(loss_q);
          end else begin
            loss_d = loss_q;
          end
        end else if (state_q == RUN) begin
          cnt_d = '0;
        end else if (cnt_q == STEP_LAST) begin
          cnt_d = '0;
          case (state_q)
            REL_SYS: state_d = REL_FB;
            REL_FB:  state_d = REL_PIX;
            default: state_d = RUN;
          endcase
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so each release lands on its transition edge.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      loss_q  <= 8'd0;
      sys_q   <= 1'b0;
      fb_q    <= 1'b0;
      pix_q   <= 1'b0;
      video_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      sys_q   <= (state_d inside {REL_SYS, REL_FB, REL_PIX, RUN});
      fb_q    <= (state_d inside {REL_FB, REL_PIX, RUN});
      pix_q   <= (state_d inside {REL_PIX, RUN});
      video_q <= (state_d == RUN);
      busy_q  <= (state_d != RUN);
    end
  end

  assign rst_sys_n     = sys_q;
  assign rst_fb_n      = fb_q;
  assign rst_pix_n     = pix_q;
  assign video_en      = video_q;
  assign busy          = busy_q;
  assign state_o       = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: a timestamp-based reference model predicts
// every output from edge counts since lock / abort, with randomized stimulus timing.
module tb_rst_sequencer;

  localparam int S = 8;
  localparam int T = 4;
  localparam int H = 4;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sw_rst_req;
  logic       rst_sys_n, rst_fb_n, rst_pix_n, video_en, busy;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt;

  int tests = 0;
  int fails = 0;

  rst_sequencer #(
    .STABLE_CYC  (S),
    .STEP_CYC    (T),
    .HOLD_CYC    (H),
    .SYNC_STAGES (2)
  ) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .sw_rst_req    (sw_rst_req),
    .rst_sys_n     (rst_sys_n),
    .rst_fb_n      (rst_fb_n),
    .rst_pix_n     (rst_pix_n),
    .video_en      (video_en),
    .busy          (busy),
    .state_o       (state_o),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Reference model. mode: 0 waiting for lock, 1 sequencing since edge e0, 2 holding since edge h.
  typedef struct packed {
    int mode;
    int e0;
    int h;
    int loss;
  } mst_t;

  mst_t       m_st;
  int         m_e;
  logic [1:0] m_sync;
  logic [15:0] exp_vec, dut_vec;

  // Number of outputs released k edges after the sequence started.
  function automatic int rel(input int k);
    if (k >= S + 3 * T) return 4;
    else if (k >= S) return 1 + (k - S) / T;
    else return 0;
  endfunction

  function automatic mst_t mstep(input mst_t s, input int e, input logic lk, input logic sw);
    mst_t n;
    n = s;
    if (s.mode == 0) begin
      if (lk) begin n.mode = 1; n.e0 = e; end
    end else if (s.mode == 1) begin
      if (rel(e - 1 - s.e0) == 0) begin
        if (!lk) n.mode = 0;
      end else if (!lk || sw) begin
        n.mode = 2;
        n.h = e;
        if (!lk && s.loss < 255) n.loss = s.loss + 1;
      end
    end else begin
      if (e == s.h + H) n.mode = 0;
    end
    return n;
  endfunction

  function automatic logic [15:0] mexp(input mst_t s, input int e);
    int r;
    logic [2:0] st;
    r = 0;
    st = 3'd0;
    if (s.mode == 1) begin
      r = rel(e - s.e0);
      st = (r == 0) ? 3'd1 : 3'(r + 1);
    end else if (s.mode == 2) begin
      st = 3'd6;
    end
    return {(r >= 1), (r >= 2), (r >= 3), (r >= 4), (r < 4), st, 8'(s.loss)};
  endfunction

  always @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      m_st   <= '{mode: 0, e0: 0, h: 0, loss: 0};
      m_e    <= 0;
      m_sync <= 2'b00;
    end else begin
      m_st   <= mstep(m_st, m_e + 1, m_sync[1], sw_rst_req);
      m_sync <= {m_sync[0], pll_locked};
      m_e    <= m_e + 1;
    end
  end

  always_comb exp_vec = mexp(m_st, m_e);
  assign dut_vec = {rst_sys_n, rst_fb_n, rst_pix_n, video_en, busy, state_o, lock_loss_cnt};

  task automatic apply_reset();
    @(negedge clk_in);
    rst = 1'b0;
    @(negedge clk_in);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pll_locked = 1'b0;
    sw_rst_req = 1'b0;
    repeat (5) @(negedge clk_in);
    tests++;
    if (dut_vec !== 16'h0800) begin
      fails++;
      $display("FAIL reset_values got %h exp %h", dut_vec, 16'h0800);
    end
    tests++;
    if (exp_vec !== 16'h0800) begin
      fails++;
      $display("FAIL reset_model got %h exp %h", exp_vec, 16'h0800);
    end
    rst = 1'b1;
  endtask

  task automatic test_power_up();
    int rise[4];
    int idle;
    int exp_rise[4];
    exp_rise = '{S + 2, S + 2 + T, S + 2 + 2 * T, S + 2 + 3 * T};
    rise = '{-1, -1, -1, -1};
    idle = int'($urandom_range(0, 4));
    repeat (idle) begin
      @(negedge clk_in);
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL power_up_idle got %h exp %h", dut_vec, exp_vec);
      end
    end
    pll_locked = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_in);
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL power_up k=%0d got %h exp %h", k, dut_vec, exp_vec);
      end
      for (int j = 0; j < 4; j++) begin
        if (rise[j] < 0 && dut_vec[15-j]) rise[j] = k;
      end
    end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (rise[j] !== exp_rise[j]) begin
        fails++;
        $display("FAIL power_up_rise%0d edge s+%0d exp s+%0d", j, rise[j], exp_rise[j]);
      end
    end
    tests++;
    if ({busy, state_o} !== {1'b0, 3'd5}) begin
      fails++;
      $display("FAIL power_up_run busy=%b state=%0d exp busy=0 state=5", busy, state_o);
    end
  endtask

  task automatic test_settle_glitch();
    int wait_k;
    int sys_k;
    wait_k = -1;
    sys_k = -1;
    pll_locked = 1'b0;
    apply_reset();
    pll_locked = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk_in);
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL glitch k=%0d got %h exp %h", k, dut_vec, exp_vec);
      end
      if (wait_k < 0 && k > 2 && state_o == 3'd0) wait_k = k;
      if (sys_k < 0 && rst_sys_n) sys_k = k;
      if (k == 3) pll_locked = 1'b0;
      if (k == 4) pll_locked = 1'b1;
    end
    tests++;
    if (wait_k !== 6) begin
      fails++;
      $display("FAIL glitch_wait_lock edge s+%0d exp s+6", wait_k);
    end
    tests++;
    if (sys_k !== S + 7) begin
      fails++;
      $display("FAIL glitch_sys_release edge s+%0d exp s+%0d", sys_k, S + 7);
    end
    tests++;
    if (lock_loss_cnt !== 8'd0) begin
      fails++;
      $display("FAIL glitch_loss_cnt got %0d exp 0", lock_loss_cnt);
    end
  endtask

  task automatic test_lock_loss_run();
    int off_k;
    int hold_n;
    off_k = -1;
    hold_n = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk_in);
    pll_locked = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL lock_loss k=%0d got %h exp %h", k, dut_vec, exp_vec);
      end
      if (off_k < 0 && dut_vec[15:12] == 4'b0000) off_k = k;
      if (state_o == 3'd6) hold_n++;
    end
    tests++;
    if (off_k < 0 || off_k > 2) begin
      fails++;
      $display("FAIL lock_loss_reaction edge a+%0d exp a+2", off_k);
    end
    tests++;
    if (hold_n !== H) begin
      fails++;
      $display("FAIL lock_loss_hold_len got %0d exp %0d", hold_n, H);
    end
    tests++;
    if (lock_loss_cnt !== 8'd1 || state_o !== 3'd0) begin
      fails++;
      $display("FAIL lock_loss_after cnt=%0d state=%0d exp cnt=1 state=0", lock_loss_cnt, state_o);
    end
    pll_locked = 1'b1;
    repeat (30) begin
      @(negedge clk_in);
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL lock_loss_reseq got %h exp %h", dut_vec, exp_vec);
      end
    end
    tests++;
    if (state_o !== 3'd5) begin
      fails++;
      $display("FAIL lock_loss_reseq_run state=%0d exp 5", state_o);
    end
  endtask

  task automatic test_sw_rst();
    bit found;
    pll_locked = 1'b0;
    apply_reset();
    sw_rst_req = 1'b1;
    @(negedge clk_in);
    sw_rst_req = 1'b0;
    repeat (3) begin
      tests++;
      if (state_o !== 3'd0 || dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL sw_ignored_wait state=%0d got %h exp %h", state_o, dut_vec, exp_vec);
      end
      @(negedge clk_in);
    end
    pll_locked = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk_in);
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL sw_seq got %h exp %h", dut_vec, exp_vec);
      end
      if (state_o == 3'd3) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL sw_reach_rel_fb state=%0d exp 3", state_o);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk_in);
    sw_rst_req = 1'b1;
    @(negedge clk_in);
    sw_rst_req = 1'b0;
    tests++;
    if ({state_o, rst_sys_n, lock_loss_cnt} !== {3'd6, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL sw_hold state=%0d sys=%b cnt=%0d exp state=6 sys=0 cnt=0",
               state_o, rst_sys_n, lock_loss_cnt);
    end
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk_in);
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL sw_reseq got %h exp %h", dut_vec, exp_vec);
      end
      if (state_o == 3'd5) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL sw_reach_run state=%0d exp 5", state_o);
    end
  endtask

  task automatic test_simultaneous();
    pll_locked = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    sw_rst_req = 1'b1;
    @(negedge clk_in);
    sw_rst_req = 1'b0;
    tests++;
    if ({state_o, lock_loss_cnt} !== {3'd6, 8'd1} || dut_vec !== exp_vec) begin
      fails++;
      $display("FAIL simultaneous state=%0d cnt=%0d exp state=6 cnt=1", state_o, lock_loss_cnt);
    end
    repeat (6) begin
      @(negedge clk_in);
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL simultaneous_hold got %h exp %h", dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_saturation_and_async_rst();
    bit found;
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        @(negedge clk_in);
        if (rst_sys_n) found = 1'b1;
      end
      repeat ($urandom_range(0, 12)) @(negedge clk_in);
      pll_locked = 1'b0;
      for (int k = 0; k < 40 && found; k++) begin
        @(negedge clk_in);
        if (state_o == 3'd0) break;
      end
      tests++;
      if (!found || state_o !== 3'd0 || dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL saturate_iter%0d got %h exp %h", i, dut_vec, exp_vec);
        break;
      end
    end
    tests++;
    if (lock_loss_cnt !== 8'd255) begin
      fails++;
      $display("FAIL saturate_cnt got %0d exp 255", lock_loss_cnt);
    end
    pll_locked = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk_in);
      if (state_o == 3'd4) found = 1'b1;
    end
    tests++;
    if (!found || dut_vec !== exp_vec) begin
      fails++;
      $display("FAIL reach_rel_pix got %h exp %h", dut_vec, exp_vec);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (dut_vec !== 16'h0800) begin
      fails++;
      $display("FAIL async_rst got %h exp %h", dut_vec, 16'h0800);
    end
    tests++;
    if (exp_vec !== 16'h0800) begin
      fails++;
      $display("FAIL async_rst_model got %h exp %h", exp_vec, 16'h0800);
    end
    @(negedge clk_in);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_settle_glitch();
    test_lock_loss_run();
    test_sw_rst();
    test_simultaneous();
    test_saturation_and_async_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
